// File: rtl/answer_arbiter.sv
// Quiz-show answer arbiter: per-channel synchronizer + debouncer feeding a lock-first FSM.
// Optional early-press (foul) detection is enabled by defining ANSWER_FOUL_DETECT_EN.
module answer_arbiter #(
    parameter logic [19:0] DB = 20'd100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] btn,
    input  logic       start,
    input  logic       clear,
    input  logic       time_up,
    output logic       run_pause,
    output logic       winner_valid,
    output logic [2:0] winner_id,
    output logic       timeout,
    output logic [7:0] foul_mask,
    output logic       beep_pulse
);

    typedef enum logic [1:0] {IDLE, ARMED, LOCKED, TIMEOUT} state_t;

    state_t     state_reg, state_next;
    logic [2:0] winner_id_reg, winner_id_next;
    logic       beep_reg, beep_next;
    logic [7:0] press;
    logic [7:0] eligible;
    logic       win_hit;
    logic [2:0] win_idx;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_chan
            logic        sync1_reg, sync2_reg, deb_reg, deb_d_reg;
            logic [19:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    deb_reg   <= 1'b0;
                    deb_d_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn[gi];
                    sync2_reg <= sync1_reg;
                    deb_d_reg <= deb_reg;
                    // Any sample agreeing with the current level restarts the stability count.
                    if (sync2_reg != deb_reg) begin
                        if (cnt_reg == DB) begin
                            deb_reg <= sync2_reg;
                            cnt_reg <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 20'd1;
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
            end

            assign press[gi] = deb_reg & ~deb_d_reg;
        end
    endgenerate

`ifdef ANSWER_FOUL_DETECT_EN
    logic [7:0] foul_reg, foul_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) foul_reg <= 8'h00;
        else        foul_reg <= foul_next;
    end

    assign foul_mask = foul_reg;
`else
    assign foul_mask = 8'h00;
`endif

    assign eligible = press & ~foul_mask;

    // Scan downward so the lowest pressed index is the one left standing.
    always_comb begin
        win_hit = 1'b0;
        win_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) begin
                win_hit = 1'b1;
                win_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        winner_id_next = winner_id_reg;
        beep_next      = 1'b0;
`ifdef ANSWER_FOUL_DETECT_EN
        foul_next      = foul_reg;
`endif
        if (clear) begin
            state_next     = IDLE;
            winner_id_next = 3'd0;
`ifdef ANSWER_FOUL_DETECT_EN
            foul_next      = 8'h00;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
`ifdef ANSWER_FOUL_DETECT_EN
                    foul_next = foul_reg | press;
                    beep_next = |(press & ~foul_reg);
`endif
                    if (start) state_next = ARMED;
                end
                ARMED: begin
                    if (win_hit) begin
                        state_next     = LOCKED;
                        winner_id_next = win_idx;
                        beep_next      = 1'b1;
                    end else if (time_up) begin
                        state_next = TIMEOUT;
                    end
                end
                LOCKED:  state_next = LOCKED;
                TIMEOUT: state_next = TIMEOUT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            winner_id_reg <= 3'd0;
            beep_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            winner_id_reg <= winner_id_next;
            beep_reg      <= beep_next;
        end
    end

    assign run_pause    = (state_reg == ARMED);
    assign winner_valid = (state_reg == LOCKED);
    assign timeout      = (state_reg == TIMEOUT);
    assign winner_id    = winner_id_reg;
    assign beep_pulse   = beep_reg;

endmodule

// File: tb/tb_answer_arbiter.sv
// Bench for answer_arbiter with DB=4: directed scenarios plus a randomized run checked
// against a window-based debounce model and a round-level reference of the game rules.
module tb_answer_arbiter;

    localparam int DBV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] btn;
    logic       start, clear, time_up;
    logic       run_pause, winner_valid, timeout, beep_pulse;
    logic [2:0] winner_id;
    logic [7:0] foul_mask;

    int n_tests = 0;
    int n_fail  = 0;

    answer_arbiter #(.DB(20'd4)) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .start(start), .clear(clear),
        .time_up(time_up), .run_pause(run_pause), .winner_valid(winner_valid),
        .winner_id(winner_id), .timeout(timeout), .foul_mask(foul_mask),
        .beep_pulse(beep_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: round phase, latched results, and raw sample history per edge.
    typedef enum {M_IDLE, M_ARMED, M_LOCKED, M_TIMEOUT} mstate_t;
    mstate_t    m_state;
    logic [2:0] m_win;
    logic [7:0] m_foul;
    logic       m_beep;
    logic [7:0] m_level;
    logic [7:0] m_pending;
    logic [7:0] hist [$];

    task automatic model_reset();
        m_state   = M_IDLE;
        m_win     = 3'd0;
        m_foul    = 8'h00;
        m_beep    = 1'b0;
        m_level   = 8'h00;
        m_pending = 8'h00;
        hist.delete();
        for (int k = 0; k < DBV + 3; k++) hist.push_back(8'h00);
    endtask

    // A button is a press once DB+1 consecutive raw samples oppose its level; the round
    // sees it DB+3 edges after the first of those samples.
    task automatic model_edge();
        logic [7:0] p, elig;
        logic       beep;
        p    = m_pending;
        beep = 1'b0;
        if (clear) begin
            m_state = M_IDLE;
            m_win   = 3'd0;
            m_foul  = 8'h00;
        end else begin
            case (m_state)
                M_IDLE: begin
`ifdef ANSWER_FOUL_DETECT_EN
                    if ((p & ~m_foul) != 8'h00) beep = 1'b1;
                    m_foul = m_foul | p;
`endif
                    if (start) m_state = M_ARMED;
                end
                M_ARMED: begin
                    elig = p & ~m_foul;
                    if (elig != 8'h00) begin
                        for (int i = 0; i < 8; i++) begin
                            if (elig[i]) begin
                                m_win = 3'(i);
                                break;
                            end
                        end
                        m_state = M_LOCKED;
                        beep    = 1'b1;
                    end else if (time_up) begin
                        m_state = M_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
        m_beep = beep;

        hist.push_back(btn);
        void'(hist.pop_front());
        for (int ch = 0; ch < 8; ch++) begin
            logic all_diff;
            all_diff = 1'b1;
            for (int k = 0; k <= DBV; k++) begin
                if (hist[k][ch] == m_level[ch]) all_diff = 1'b0;
            end
            m_pending[ch] = 1'b0;
            if (all_diff) begin
                m_level[ch]   = ~m_level[ch];
                m_pending[ch] = m_level[ch];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_settle(input int n);
        start = 0; clear = 0; time_up = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst_n = 0; btn = 8'h00; start = 0; clear = 0; time_up = 0;
        model_reset();
        #3;
        if ({run_pause, winner_valid, winner_id, timeout, foul_mask, beep_pulse} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {run_pause, winner_valid, winner_id, timeout, foul_mask, beep_pulse});
        end
        n_tests++;
        #19 rst_n = 1;
        idle_settle(3);
        if (run_pause !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_run_pause: got %b required 0", run_pause);
        end
        n_tests++;
        $display("[TB] test_reset done");
    endtask

    task automatic test_single_press();
        start = 1; step(); start = 0;
        btn = 8'h20;
        for (int i = 0; i <= 8; i++) begin
            step();
            if (winner_valid !== (i >= 7)) begin
                n_fail++; $display("FAIL single_valid_c%0d: got %b required %b", i, winner_valid, i >= 7);
            end
            n_tests++;
            if (beep_pulse !== (i == 7)) begin
                n_fail++; $display("FAIL single_beep_c%0d: got %b required %b", i, beep_pulse, i == 7);
            end
            n_tests++;
        end
        if (winner_id !== 3'd5 || run_pause !== 1'b0) begin
            n_fail++; $display("FAIL single_id: got id=%0d run=%b required id=5 run=0", winner_id, run_pause);
        end
        n_tests++;
        btn = 8'h00; clear = 1; step(); idle_settle(8);
        $display("[TB] test_single_press done");
    endtask

    task automatic test_simultaneous();
        start = 1; step(); start = 0;
        btn = 8'h48;
        for (int i = 0; i < 8; i++) step();
        if (winner_valid !== 1'b1 || winner_id !== 3'd3) begin
            n_fail++; $display("FAIL simul_id: got v=%b id=%0d required v=1 id=3", winner_valid, winner_id);
        end
        n_tests++;
        btn = 8'h49;
        for (int i = 0; i < 10; i++) begin
            step();
            if (winner_id !== 3'd3 || beep_pulse !== 1'b0) begin
                n_fail++; $display("FAIL simul_hold_c%0d: got id=%0d beep=%b required id=3 beep=0", i, winner_id, beep_pulse);
            end
            n_tests++;
        end
        btn = 8'h00; clear = 1; step(); idle_settle(8);
        $display("[TB] test_simultaneous done");
    endtask

    task automatic test_glitch_timeout();
        start = 1; step(); start = 0;
        btn = 8'h04;
        for (int i = 0; i < 3; i++) step();
        btn = 8'h00;
        for (int i = 0; i < 10; i++) step();
        if (run_pause !== 1'b1 || winner_valid !== 1'b0) begin
            n_fail++; $display("FAIL glitch_armed: got run=%b v=%b required run=1 v=0", run_pause, winner_valid);
        end
        n_tests++;
        time_up = 1; step(); time_up = 0;
        if (timeout !== 1'b1 || run_pause !== 1'b0) begin
            n_fail++; $display("FAIL timeout_flag: got to=%b run=%b required to=1 run=0", timeout, run_pause);
        end
        n_tests++;
        btn = 8'h01; start = 1;
        for (int i = 0; i < 9; i++) step();
        start = 0;
        if (timeout !== 1'b1 || winner_valid !== 1'b0) begin
            n_fail++; $display("FAIL timeout_hold: got to=%b v=%b required to=1 v=0", timeout, winner_valid);
        end
        n_tests++;
        btn = 8'h00; clear = 1; step(); idle_settle(8);
        $display("[TB] test_glitch_timeout done");
    endtask

    task automatic test_foul();
        int beeps;
        logic [7:0] exp_mask;
        logic [2:0] exp_id;
        int exp_beeps;
`ifdef ANSWER_FOUL_DETECT_EN
        exp_mask = 8'h02; exp_id = 3'd4; exp_beeps = 1;
`else
        exp_mask = 8'h00; exp_id = 3'd1; exp_beeps = 0;
`endif
        beeps = 0;
        btn = 8'h02;
        for (int i = 0; i < 10; i++) begin
            step();
            if (beep_pulse === 1'b1) beeps++;
        end
        if (foul_mask !== exp_mask || beeps != exp_beeps || run_pause !== 1'b0) begin
            n_fail++; $display("FAIL foul_idle: got mask=%h beeps=%0d run=%b required mask=%h beeps=%0d run=0",
                               foul_mask, beeps, run_pause, exp_mask, exp_beeps);
        end
        n_tests++;
        btn = 8'h00; idle_settle(8);
        start = 1; step(); start = 0;
        btn = 8'h02;
        for (int i = 0; i < 10; i++) step();
        btn = 8'h12;
        for (int i = 0; i < 10; i++) step();
        if (winner_valid !== 1'b1 || winner_id !== exp_id || foul_mask !== exp_mask) begin
            n_fail++; $display("FAIL foul_winner: got v=%b id=%0d mask=%h required v=1 id=%0d mask=%h",
                               winner_valid, winner_id, foul_mask, exp_id, exp_mask);
        end
        n_tests++;
        btn = 8'h00; clear = 1; step(); idle_settle(8);
        $display("[TB] test_foul done");
    endtask

    task automatic test_clear_start();
        start = 1; step(); start = 0;
        btn = 8'h01;
        for (int i = 0; i < 8; i++) step();
        if (winner_valid !== 1'b1) begin
            n_fail++; $display("FAIL cs_locked: got v=%b required 1", winner_valid);
        end
        n_tests++;
        clear = 1; start = 1; step(); clear = 0; start = 0;
        if ({run_pause, winner_valid, winner_id, timeout, foul_mask} !== 14'd0) begin
            n_fail++; $display("FAIL cs_idle: got %h required 0", {run_pause, winner_valid, winner_id, timeout, foul_mask});
        end
        n_tests++;
        step(); step();
        if (run_pause !== 1'b0) begin
            n_fail++; $display("FAIL cs_start_ignored: got run=%b required 0", run_pause);
        end
        n_tests++;
        btn = 8'h00; idle_settle(8);
        $display("[TB] test_clear_start done");
    endtask

    task automatic test_async_reset();
        start = 1; step(); start = 0;
        btn = 8'h04;
        step();
        if (run_pause !== 1'b1) begin
            n_fail++; $display("FAIL ar_armed: got run=%b required 1", run_pause);
        end
        n_tests++;
        rst_n = 0;
        #1;
        if ({run_pause, winner_valid, winner_id, timeout, foul_mask, beep_pulse} !== 15'd0) begin
            n_fail++; $display("FAIL ar_immediate: got %h required 0",
                               {run_pause, winner_valid, winner_id, timeout, foul_mask, beep_pulse});
        end
        n_tests++;
        model_reset();
        #1 rst_n = 1;
        start = 1; step(); start = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (winner_valid !== (i >= 7)) begin
                n_fail++; $display("FAIL ar_repress_c%0d: got v=%b required %b", i, winner_valid, i >= 7);
            end
            n_tests++;
        end
        if (winner_id !== 3'd2) begin
            n_fail++; $display("FAIL ar_id: got %0d required 2", winner_id);
        end
        n_tests++;
        btn = 8'h00; clear = 1; step(); idle_settle(8);
        $display("[TB] test_async_reset done");
    endtask

    task automatic test_random();
        int hold;
        int errs;
        hold = 0;
        errs = 0;
        clear = 1; step(); clear = 0;
        for (int c = 0; c < 2000; c++) begin
            if (hold == 0) begin
                btn  = btn ^ (8'h01 << 3'($urandom_range(7, 0)));
                hold = $urandom_range(12, 1);
            end else begin
                hold--;
            end
            start = ($urandom_range(5, 0) == 0);
            clear = ($urandom_range(40, 0) == 0);
            if ($urandom_range(9, 0) == 0) time_up = ~time_up;
            step();
            if (run_pause !== (m_state == M_ARMED) || winner_valid !== (m_state == M_LOCKED) ||
                timeout !== (m_state == M_TIMEOUT) || winner_id !== m_win ||
                foul_mask !== m_foul || beep_pulse !== m_beep) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_c%0d: got run=%b v=%b to=%b id=%0d mask=%h beep=%b required run=%b v=%b to=%b id=%0d mask=%h beep=%b",
                             c, run_pause, winner_valid, timeout, winner_id, foul_mask, beep_pulse,
                             m_state == M_ARMED, m_state == M_LOCKED, m_state == M_TIMEOUT,
                             m_win, m_foul, m_beep);
            end
            n_tests++;
        end
        start = 0; clear = 0; time_up = 0;
        $display("[TB] test_random done, %0d cycle errors", errs);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_simultaneous();
        test_glitch_timeout();
        test_foul();
        test_clear_start();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/answer_arbiter.md
ANSWER_ARBITER -- requirements
Module: answer_arbiter

Interface
REQ-001 The block SHALL have parameter DB, default 20'd100000, meaning the debounce stable-time in clk cycles (1 ms at 100 MHz); legal range 1..2^20-1.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state is clocked on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port btn, input, 8, raw asynchronous player buttons, active-high, channel i = bit i.
REQ-005 The block SHALL have port start, input, 1, host one-cycle pulse opening a round.
REQ-006 The block SHALL have port clear, input, 1, host one-cycle pulse ending a round.
REQ-007 The block SHALL have port time_up, input, 1, level from the countdown timer meaning time expired.
REQ-008 The block SHALL have port run_pause, output, 1, high while the countdown is to run.
REQ-009 The block SHALL have port winner_valid, output, 1, high while a winner is latched.
REQ-010 The block SHALL have port winner_id, output, 3, index of the latched winner.
REQ-011 The block SHALL have port timeout, output, 1, high while the round ended with no answer.
REQ-012 The block SHALL have port foul_mask, output, 8, channels disqualified this round for pressing early.
REQ-013 The block SHALL have port beep_pulse, output, 1, one-cycle pulse to trigger the beeper.

Function
REQ-014 Each channel SHALL pass btn through a 2-flop synchronizer, then a debouncer whose level changes only after the synchronized value differs from it for DB consecutive cycles.
REQ-015 A press event SHALL be a one-cycle pulse on the debounced rising edge; a raw rise held steady yields winner_valid exactly DB+3 cycles after the first sampling edge (ARMED, channel eligible).
REQ-016 The FSM SHALL have states IDLE, ARMED, LOCKED, TIMEOUT.
REQ-017 IDLE: run_pause=0; start -> ARMED on the next edge.
REQ-018 ARMED: run_pause=1; a press from any channel not in foul_mask -> LOCKED, latching winner_id; else time_up=1 -> TIMEOUT.
REQ-019 Simultaneous eligible presses in one cycle SHALL resolve to the lowest index.
REQ-020 A press and time_up in the same ARMED cycle SHALL resolve to LOCKED.
REQ-021 LOCKED: run_pause=0, winner_valid=1, winner_id held; further presses, start and time_up ignored.
REQ-022 TIMEOUT: run_pause=0, timeout=1; presses, start ignored.
REQ-023 clear SHALL return any state to IDLE, zero winner_valid, winner_id, timeout, foul_mask, and take priority over start, press and time_up in the same cycle.
REQ-024 start outside IDLE SHALL be ignored; start and a press in the same IDLE cycle SHALL enter ARMED with that press treated as early (REQ-027).
REQ-025 beep_pulse SHALL assert for exactly one cycle on the edge entering LOCKED and on each edge a foul bit newly sets.
REQ-026 If all 8 channels are in foul_mask, ARMED SHALL leave only via time_up or clear.

Configuration
REQ-027 With macro ANSWER_FOUL_DETECT_EN defined, a press in IDLE SHALL set foul_mask bit i (sticky until clear) and that channel SHALL be ineligible in the following ARMED.
REQ-028 Without ANSWER_FOUL_DETECT_EN, presses in IDLE SHALL be ignored, foul_mask SHALL be tied to 8'h00, and no foul beep SHALL occur.

Reset
REQ-029 On rst_n=0, immediately and asynchronously: state=IDLE, run_pause=0, winner_valid=0, winner_id=3'd0, timeout=0, foul_mask=8'h00, beep_pulse=0, synchronizers, debounced levels and debounce counters=0.
REQ-030 Reset mid-round SHALL discard the round; a button held through reset release SHALL register as a new press after DB+3 cycles.

Verification
REQ-031 DB=4; start, then btn[5] high steady -> winner_valid=1, winner_id=5, run_pause=0, one beep_pulse, at cycle 7 after the sampling edge.
REQ-032 DB=4; ARMED, btn[3] and btn[6] rise on the same edge -> winner_id=3; later btn[0] press -> no change.
REQ-033 DB=4; btn[2] glitches high 3 cycles during ARMED -> no press, state stays ARMED; then time_up=1 -> timeout=1, run_pause=0.
REQ-034 ANSWER_FOUL_DETECT_EN defined; btn[1] pressed in IDLE -> foul_mask=8'h02, one beep; start, btn[1] re-pressed then btn[4] -> winner_id=4.
REQ-035 In LOCKED assert clear and start same cycle -> IDLE, all flags 0, start ignored; rst_n pulsed low in ARMED -> all outputs at reset values within the same cycle.
